// File: rtl/cpu_types_pkg.sv
// Shared CPU control types: PC next-value select and fetch sequencer states.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,
    PC_JR     = 2'b01,
    PC_BRANCH = 2'b10,
    PC_JUMP   = 2'b11
  } pcsrc_t;

  typedef enum logic [1:0] {
    FETCH      = 2'b00,
    REDIR_WAIT = 2'b01,
    HALTED     = 2'b10
  } fetch_state_t;

  function automatic logic is_redirect(input pcsrc_t src);
    return (src != PC_SEQ);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // next count: step only while below the ceiling
  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != {W{1'b1}})) begin
      count_d = count_q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // count register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/fetch_ctrl.sv
// PC/fetch sequencer: PC load enable and select, icache read request,
// pipeline flushes on redirects, EX freeze while a redirect waits on a miss, halt.
module fetch_ctrl
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [1:0]       redirect_src,
  input  logic             halt,
  output logic             pcenable,
  output logic [1:0]       pcsrc,
  output logic             imemREN,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             ex_hold,
  output logic             halted,
  output logic [CNT_W-1:0] fetch_cnt,
  output logic [CNT_W-1:0] redirect_cnt
);

  fetch_state_t state_q, state_d;
  pcsrc_t       pend_q, pend_d;
  pcsrc_t       pcsrc_s;
  logic         ihit_s, stall_s, rv_s, halt_s;
  logic         flush_s;

  // Inputs read as 0 while reset is held, so outputs show plain FETCH values.
  assign ihit_s  = ihit & nRST;
  assign stall_s = stall & nRST;
  assign rv_s    = redirect_valid & nRST;
  assign halt_s  = halt & nRST;

  // Mealy next-state and output decode
  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    pcenable = 1'b0;
    pcsrc_s  = PC_SEQ;
    imemREN  = 1'b0;
    flush_s  = 1'b0;
    ex_hold  = 1'b0;
    halted   = 1'b0;
    case (state_q)
      FETCH: begin
        imemREN = 1'b1;
        if (halt_s) begin
          flush_s = 1'b1;
          state_d = HALTED;
        end else if (rv_s) begin
          if (ihit_s) begin
            pcenable = 1'b1;
            pcsrc_s  = pcsrc_t'(redirect_src);
            flush_s  = 1'b1;
          end else begin
            ex_hold = 1'b1;
            pend_d  = pcsrc_t'(redirect_src);
            state_d = REDIR_WAIT;
          end
        end else if (stall_s) begin
          pcenable = 1'b0;
        end else begin
          pcenable = ihit_s;
        end
      end
      // EX is frozen here, so redirect/stall/halt inputs are stale and ignored.
      REDIR_WAIT: begin
        imemREN = 1'b1;
        ex_hold = 1'b1;
        if (ihit_s) begin
          pcenable = 1'b1;
          pcsrc_s  = pend_q;
          flush_s  = 1'b1;
          state_d  = FETCH;
        end else begin
          state_d = REDIR_WAIT;
        end
      end
      HALTED: begin
        halted = 1'b1;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  assign pcsrc      = pcsrc_s;
  assign ifid_flush = flush_s;
  assign idex_flush = flush_s;

  // FSM state and pending redirect target
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= FETCH;
      pend_q  <= PC_SEQ;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_fetch_cnt (
    .clk_i   (CLK),
    .rst_ni  (nRST),
    .inc_i   (pcenable),
    .count_o (fetch_cnt)
  );

  sat_counter #(.W(CNT_W)) u_redirect_cnt (
    .clk_i   (CLK),
    .rst_ni  (nRST),
    .inc_i   (pcenable & is_redirect(pcsrc_s)),
    .count_o (redirect_cnt)
  );

endmodule
